global_pool_layer: RTL and testbench
====================================

Name: global_pool_layer

Overview:
Parametrised successor to the per-kernel global-average-pooling stage. One instance pools all NUM_CHANNELS convolution channels from a single channel-interleaved serial stream. It supports average or max pooling, selected per frame, and emits a serial per-channel result stream. It sits between the convolution outputs and the double_fifo feeding the first fc_layer, replacing the per-channel gap instances and the packed-to-serial fc_output stage.

Parameters:
WORD_SIZE, 16, data word width in bits (signed fixed point)
N_SIZE, 12, fractional bits of data words
INPUT_SIZE, 241, positions per channel per frame
NUM_CHANNELS, 256, interleaved channels; element k belongs to channel k mod NUM_CHANNELS

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, asynchronous, active-low
mode_i  in  1  0 = average, 1 = max; sampled when the first element of a frame is accepted
valid_i  in  1  input element valid
ready_o  out  1  block can accept input
data_r_i  in  WORD_SIZE  signed input element
valid_o  out  1  output result valid (helpful)
ready_i  in  1  downstream accepts result
data_r_o  out  WORD_SIZE  signed pooled result, channel order 0..NUM_CHANNELS-1
last_o  out  1  high with the result for channel NUM_CHANNELS-1

Behaviour:
- Reset (reset_i low, asynchronous): state=ACCUM, ch_cnt=0, pos_cnt=0, mode_r=0, valid_o=0, data_r_o=0, last_o=0. ready_o=1 one cycle after release. Accumulator contents are don't-care.
- Accumulator array: NUM_CHANNELS x ACC_W, where ACC_W = WORD_SIZE + clog2(INPUT_SIZE), signed.
- State ACCUM: ready_o=1, valid_o=0.
  - Input handshake is valid_i & ready_o.
  - When pos_cnt==0, acc[ch_cnt] = sign-extended data. No clear cycle is needed.
  - Otherwise, avg mode: acc += data. Max mode: acc = signed max(acc, data).
  - On the first element (pos 0, ch 0), mode_r <= mode_i. mode_i is ignored for the rest of the frame.
  - ch_cnt wraps at NUM_CHANNELS-1 and increments pos_cnt.
  - Handshake on pos_cnt==INPUT_SIZE-1 and ch_cnt==NUM_CHANNELS-1: go to DRAIN and set ch_cnt=0.
- State DRAIN: ready_o=0.
  - Output register loads result(ch_cnt); valid_o rises the cycle after the final input is accepted (latency 1).
  - Result, avg mode: (acc * RECIP) >>> N_SIZE, with RECIP = round(2^N_SIZE / INPUT_SIZE). Arithmetic shift truncates toward -inf. Saturate to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
  - Result, max mode: acc[WORD_SIZE-1:0] (always in range).
  - On valid_o & ready_i, advance to the next channel. Throughput is 1 result/cycle under constant ready_i.
  - While ready_i=0, data_r_o, last_o and valid_o hold stable.
  - After the last_o handshake: valid_o=0, state=ACCUM, counters=0. ready_o is high the next cycle.
- Input is never accepted during DRAIN. Frames do not overlap.
- Multiplier width: ACC_W + N_SIZE + 1 bits, signed. Saturation happens after the shift.
- Reset asserted mid-frame or mid-drain aborts the frame. No partial output is emitted after reset.

Optional Feature:
- Macro GLOBAL_POOL_ABS_EN.
- Defined: an absolute value is fused on data_r_i before accumulation, replacing a separate abs stage. abs(-2^(WORD_SIZE-1)) saturates to 2^(WORD_SIZE-1)-1. No added latency.
- Undefined: data is used as-is (signed).

Decomposition:
- Package pool_pkg:
  - pool_mode_e enum (POOL_AVG=0, POOL_MAX=1)
  - pool_state_e enum (ACCUM, DRAIN)
  - function sat_word(value, width)
  - function recip_const(INPUT_SIZE, N_SIZE)
- One sub-module, pool_div_sat: combinational reciprocal-multiply, shift and saturate; parameters WORD_SIZE, N_SIZE, ACC_W, RECIP.
- Counters, FSM and accumulator array stay in global_pool_layer.

Test Plan (WORD_SIZE=16, N_SIZE=12, INPUT_SIZE=4, NUM_CHANNELS=4, RECIP=1024):
- Avg: all 16 inputs 0x1000, mode_i=0, ready_i=1 -> four results 0x1000, last_o on the 4th; valid_o rises 1 cycle after the 16th accept; ready_o=0 throughout drain.
- Max: channel 2 positions {0xF000, 0x0300, 0x0100, 0x8000}, mode_i=1 -> channel 2 result 0x0300; channel with all 0x8000 -> 0x8000.
- Signed avg: channel 0 {0x2000, 0xF000, 0xF000, 0x0000} -> sum 0x0000 -> result 0x0000; channel 1 {0xFFFF x4} -> 0xFFFF (truncation toward -inf).
- Backpressure: ready_i held low 5 cycles mid-drain -> data_r_o/last_o stable, no channel skipped, valid_i ignored (no accept) during drain.
- Mode latch: mode_i toggles 0->1 after the first element -> frame still averaged; next frame with mode_i=1 at start -> max.
- Reset: reset_i low during the 2nd drain result -> valid_o=0 immediately; after release a new 16-element frame produces only fresh results. With GLOBAL_POOL_ABS_EN, inputs 0x8000 x4 in avg -> 0x7FFF.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and helpers for the global pooling layer.
// Pool modes, FSM states, saturation and reciprocal constant.
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } pool_state_e;

  function automatic logic signed [63:0] sat_word(
    input logic signed [63:0] value,
    input int                 width
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic int recip_const(
    input int input_size,
    input int n_size
  );
    return ((1 << n_size) + input_size / 2) / input_size;
  endfunction

endpackage

// File: rtl/pool_div_sat.sv
// Divide-by-count via reciprocal multiply, floor shift, saturate.
// Ports: acc (signed sum) -> result (signed WORD_SIZE word).
module pool_div_sat
  import pool_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int N_SIZE    = 12,
  parameter int ACC_W     = 20,
  parameter int RECIP     = 17
) (
  input  logic signed [ACC_W-1:0]     acc,
  output logic signed [WORD_SIZE-1:0] result
);

  localparam int MW = ACC_W + N_SIZE + 1;

  logic signed [MW-1:0] prod;
  logic signed [MW-1:0] shifted;

  always_comb begin
    prod    = MW'(acc) * MW'(RECIP);
    // arithmetic shift floors toward -inf
    shifted = prod >>> N_SIZE;
    result  = WORD_SIZE'(sat_word(64'(shifted), WORD_SIZE));
  end

endmodule

// File: rtl/global_pool_layer.sv
// Global avg/max pooling over a channel-interleaved serial stream.
// Ports: clk_i, reset_i (async low); in: mode_i/valid_i/ready_o/data_r_i;
// out: valid_o/ready_i/data_r_o/last_o. Macro GLOBAL_POOL_ABS_EN fuses abs.
module global_pool_layer
  import pool_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int N_SIZE       = 12,
  parameter int INPUT_SIZE   = 241,
  parameter int NUM_CHANNELS = 256
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        mode_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [WORD_SIZE-1:0] data_r_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [WORD_SIZE-1:0]        data_r_o,
  output logic                        last_o
);

  localparam int ACC_W = WORD_SIZE + $clog2(INPUT_SIZE);
  localparam int RECIP = recip_const(INPUT_SIZE, N_SIZE);
  localparam int CH_W  =
    (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int POS_W =
    (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(INPUT_SIZE - 1);

  pool_state_e state, state_nx;
  pool_mode_e  mode_r, mode_cur;

  logic [CH_W-1:0]  ch_cnt, ch_nx, rd_ch;
  logic [POS_W-1:0] pos_cnt;

  logic signed [ACC_W-1:0] acc [NUM_CHANNELS];
  logic signed [ACC_W-1:0] acc_cur, acc_nx, ext, rd_acc;

  logic signed [WORD_SIZE-1:0] din, avg_res, res;
  logic take, first, frame_end;

`ifdef GLOBAL_POOL_ABS_EN
  localparam logic [WORD_SIZE-1:0] W_MIN =
    {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam logic [WORD_SIZE-1:0] W_MAX =
    {1'b0, {(WORD_SIZE-1){1'b1}}};

  always_comb begin
    din = data_r_i;
    if (data_r_i[WORD_SIZE-1]) begin
      if (data_r_i == W_MIN) din = W_MAX;
      else                   din = -data_r_i;
    end
  end
`else
  assign din = data_r_i;
`endif

  assign take      = valid_i & ready_o;
  assign first     = (state == ACCUM) &&
                     (pos_cnt == '0) && (ch_cnt == '0);
  assign frame_end = take && (pos_cnt == POS_LAST) &&
                     (ch_cnt == CH_LAST);
  assign ch_nx     = ch_cnt + 1'b1;

  // mode_i is live only on the frame's first element
  assign mode_cur = first ? pool_mode_e'(mode_i) : mode_r;

  always_comb begin
    ext     = ACC_W'(din);
    acc_cur = acc[ch_cnt];
    acc_nx  = acc_cur + ext;
    if (pos_cnt == '0)
      acc_nx = ext;
    else if (mode_cur == POOL_MAX)
      acc_nx = (ext > acc_cur) ? ext : acc_cur;
  end

  // next result to load; bypass covers a same-cycle write
  always_comb begin
    rd_ch = '0;
    if (state == DRAIN && ch_cnt != CH_LAST) rd_ch = ch_nx;
    rd_acc = acc[rd_ch];
    if (take && ch_cnt == rd_ch) rd_acc = acc_nx;
  end

  pool_div_sat #(
    .WORD_SIZE (WORD_SIZE),
    .N_SIZE    (N_SIZE),
    .ACC_W     (ACC_W),
    .RECIP     (RECIP)
  ) u_div (
    .acc    (rd_acc),
    .result (avg_res)
  );

  assign res = (mode_cur == POOL_MAX) ?
               rd_acc[WORD_SIZE-1:0] : avg_res;

  always_ff @(posedge clk_i) begin
    if (take) acc[ch_cnt] <= acc_nx;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= ACCUM;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM: if (frame_end) state_nx = DRAIN;
      DRAIN: if (valid_o && ready_i && last_o) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ch_cnt   <= '0;
      pos_cnt  <= '0;
      mode_r   <= POOL_AVG;
      valid_o  <= 1'b0;
      data_r_o <= '0;
      last_o   <= 1'b0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          ready_o <= !frame_end;
          if (take) begin
            if (first) mode_r <= pool_mode_e'(mode_i);
            if (ch_cnt == CH_LAST) begin
              ch_cnt  <= '0;
              pos_cnt <= frame_end ? '0 : pos_cnt + 1'b1;
            end else begin
              ch_cnt <= ch_nx;
            end
            if (frame_end) begin
              valid_o  <= 1'b1;
              data_r_o <= res;
              last_o   <= (NUM_CHANNELS == 1);
            end
          end
        end
        DRAIN: begin
          if (valid_o && ready_i) begin
            if (last_o) begin
              valid_o <= 1'b0;
              last_o  <= 1'b0;
              ch_cnt  <= '0;
              pos_cnt <= '0;
              ready_o <= 1'b1;
            end else begin
              ch_cnt   <= ch_nx;
              data_r_o <= res;
              last_o   <= (ch_nx == CH_LAST);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_global_pool_layer.sv
// Scoreboard bench for global_pool_layer (4 ch x 4 pos, N=12).
// Directed frames; monitor pops expected results on each handshake.
module tb_global_pool_layer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        mode_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] data_r_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [15:0] data_r_o;
  logic        last_o;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          nchk = 0;
  int          nfail = 0;
  logic [15:0] fr_d [16];
  logic [15:0] fr_e [4];

  always #5 clk = ~clk;

  global_pool_layer #(
    .WORD_SIZE    (16),
    .N_SIZE       (12),
    .INPUT_SIZE   (4),
    .NUM_CHANNELS (4)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .mode_i   (mode_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_r_i (data_r_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_r_o (data_r_o),
    .last_o   (last_o)
  );

  function automatic void check(
    string name, logic [31:0] act, logic [31:0] req
  );
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (valid_o) check("ready_in_drain", 32'(ready_o), 0);
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(data_r_o), 32'hDEAD);
        end else begin
          e = sb.pop_front();
          check("result", {15'd0, last_o, data_r_o},
                {15'd0, e.last, e.data});
        end
      end
    end
  end

  task automatic send_frame(
    input logic m0, input logic m1, input logic garbage
  );
    for (int i = 0; i < 4; i++)
      sb.push_back({(i == 3), fr_e[i]});
    for (int k = 0; k < 16; k++) begin
      int w = 0;
      while (!ready_o && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("ready_wait", 32'(w >= 50), 0);
      valid_i  = 1'b1;
      data_r_i = fr_d[k];
      mode_i   = (k == 0) ? m0 : m1;
      if (k == 15) check("valid_early", 32'(valid_o), 0);
      @(posedge clk);
      @(negedge clk);
    end
    check("valid_latency", 32'(valid_o), 1);
    valid_i  = garbage;
    data_r_i = 16'h7777;
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((sb.size() != 0 || valid_o) && w < 200) begin
      @(negedge clk);
      #2;
      w++;
    end
    check("drain_timeout", 32'(w >= 200), 0);
    check("ready_after_drain", 32'(ready_o), 1);
  endtask

  task automatic load_f3();
    fr_d = '{16'h2000, 16'hFFFF, 16'h7FFF, 16'h8000,
             16'hF000, 16'hFFFF, 16'h7FFF, 16'h8000,
             16'hF000, 16'hFFFF, 16'h7FFF, 16'h8000,
             16'h0000, 16'hFFFF, 16'h7FFF, 16'h7FFF};
    fr_e = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'hBFFF};
  endtask

  task automatic load_f4(input logic mx);
    fr_d = '{16'h0400, 16'h0010, 16'h0000, 16'hFFF8,
             16'h0800, 16'h0020, 16'h0000, 16'h0000,
             16'h0C00, 16'h0030, 16'h0000, 16'h0000,
             16'h1000, 16'h0040, 16'h0000, 16'h0000};
    if (mx) fr_e = '{16'h1000, 16'h0040, 16'h0000, 16'h0000};
    else    fr_e = '{16'h0A00, 16'h0028, 16'h0000, 16'hFFFE};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] hd;
    logic        hl;
    #12;
    check("rst_valid", 32'(valid_o), 0);
    check("rst_data", 32'(data_r_o), 0);
    check("rst_last", 32'(last_o), 0);
    check("rst_ready", 32'(ready_o), 0);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(ready_o), 1);

    for (int i = 0; i < 16; i++) fr_d[i] = 16'h1000;
    for (int i = 0; i < 4; i++) fr_e[i] = 16'h1000;
    send_frame(1'b0, 1'b0, 1'b0);
    wait_drain();

`ifdef GLOBAL_POOL_ABS_EN
    for (int i = 0; i < 16; i++) fr_d[i] = 16'h8000;
    for (int i = 0; i < 4; i++) fr_e[i] = 16'h7FFF;
    send_frame(1'b0, 1'b0, 1'b0);
    wait_drain();
`else
    fr_d = '{16'h0001, 16'hFFFF, 16'hF000, 16'h8000,
             16'h0002, 16'hFFFE, 16'h0300, 16'h8000,
             16'h0003, 16'h8000, 16'h0100, 16'h8000,
             16'h0004, 16'hFFF0, 16'h8000, 16'h8000};
    fr_e = '{16'h0004, 16'hFFFF, 16'h0300, 16'h8000};
    send_frame(1'b1, 1'b1, 1'b0);
    wait_drain();

    load_f3();
    send_frame(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    ready_i = 1'b0;
    hd = data_r_o;
    hl = last_o;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("hold_data", 32'(data_r_o), 32'(hd));
      check("hold_last", 32'(last_o), 32'(hl));
      check("hold_valid", 32'(valid_o), 1);
    end
    ready_i = 1'b1;
    wait_drain();
    valid_i = 1'b0;

    load_f4(1'b0);
    send_frame(1'b0, 1'b1, 1'b0);
    wait_drain();
    load_f4(1'b1);
    send_frame(1'b1, 1'b0, 1'b0);
    wait_drain();

    for (int i = 0; i < 16; i++) fr_d[i] = 16'h0800;
    for (int i = 0; i < 4; i++) fr_e[i] = 16'h0800;
    send_frame(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_i = 1'b0;
    sb.delete();
    #1;
    check("abort_valid", 32'(valid_o), 0);
    check("abort_last", 32'(last_o), 0);
    check("abort_data", 32'(data_r_o), 0);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    check("ready_after_abort", 32'(ready_o), 1);
    load_f3();
    send_frame(1'b0, 1'b0, 1'b0);
    wait_drain();
`endif

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
